// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver: scans a double-buffered nibble
// vector across NUM_DIGITS common-anode digits with PWM brightness,
// per-digit blanking/decimal points and a frame_done strobe.
module seg7_scan_mux #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DUTY_BITS   = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   digit_data,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      load,
   input  logic [DUTY_BITS-1:0]      brightness,
   output logic [NUM_DIGITS-1:0]     ENABLE,
   output logic [6:0]                LEDOUT,
   output logic                      DP,
   output logic                      frame_done
);

   localparam int unsigned SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned SUB_LEN = REFRESH_DIV >> DUTY_BITS;
   localparam int unsigned SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_LEN - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   // One displayable frame: nibbles, decimal points and blank mask.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] data;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
   } frame_t;

   logic [SLOT_W-1:0]    slot_cnt;
   logic [SUB_W-1:0]     sub_cnt;
   logic [DUTY_BITS-1:0] subphase;
   logic [IDX_W-1:0]     digit_idx;
   logic [DUTY_BITS-1:0] bright_q;
   frame_t               hold;
   frame_t               disp;

   logic                 frame_evt_c;
   logic [DUTY_BITS-1:0] bright_eff_c;
   frame_t               load_frame_c;
   logic [3:0]           nib_c;
   logic                 lit_c;
   logic [NUM_DIGITS-1:0] en_c;
   logic [6:0]           led_c;
   logic                 dp_c;

   // Active-low hex decode, segments ordered {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Frame event, brightness in effect for this sub-phase, incoming frame.
   always_comb begin
      frame_evt_c  = (slot_cnt == SLOT_LAST) && (digit_idx == IDX_LAST);
      bright_eff_c = (sub_cnt == '0) ? brightness : bright_q;
      load_frame_c = {digit_data, dp_in, blank};
   end

   // Slot, sub-phase and digit counters; subphase tracks slot_cnt / SUB_LEN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_cnt  <= '0;
         sub_cnt   <= '0;
         subphase  <= '0;
         digit_idx <= '0;
      end else if (slot_cnt == SLOT_LAST) begin
         slot_cnt  <= '0;
         sub_cnt   <= '0;
         subphase  <= '0;
         digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end else begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
         if (sub_cnt == SUB_LAST) begin
            sub_cnt  <= '0;
            subphase <= subphase + DUTY_BITS'(1);
         end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
         end
      end
   end

   // Brightness is frozen for the remainder of each sub-phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) bright_q <= '0;
      else        bright_q <= bright_eff_c;
   end

   // Holding register takes any load; display register swaps only at frame end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold       <= '0;
         disp       <= '0;
         frame_done <= 1'b0;
      end else begin
         if (load)        hold <= load_frame_c;
         if (frame_evt_c) disp <= load ? load_frame_c : hold;
         frame_done <= frame_evt_c;
      end
   end

   // Current digit's drive; everything dark when the digit is off.
   always_comb begin
      en_c  = '1;
      led_c = 7'h7F;
      dp_c  = 1'b1;
      nib_c = disp.data[{digit_idx, 2'b00} +: 4];
      lit_c = (subphase <= bright_eff_c) && !disp.blank[digit_idx];
      if (lit_c) begin
         en_c[digit_idx] = 1'b0;
         led_c           = seg_decode(nib_c);
         dp_c            = ~disp.dp[digit_idx];
      end
   end

   // Registered pad drive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ENABLE <= '1;
         LEDOUT <= 7'h7F;
         DP     <= 1'b1;
      end else begin
         ENABLE <= en_c;
         LEDOUT <= led_c;
         DP     <= dp_c;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a positional reference model pushes
// the expected pad state per cycle, a monitor pops and compares.
`timescale 1ns/1ps
module tb_seg7_scan_mux;

   localparam int unsigned ND    = 4;
   localparam int unsigned RD    = 16;
   localparam int unsigned DB    = 3;
   localparam int unsigned SUBL  = RD >> DB;
   localparam int unsigned FRAME = RD * ND;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   digit_data = '0;
   logic [3:0]    dp_in = '0;
   logic [3:0]    blank = '0;
   logic          load = 1'b0;
   logic [2:0]    brightness = 3'd7;
   logic [3:0]    ENABLE;
   logic [6:0]    LEDOUT;
   logic          DP;
   logic          frame_done;

   always #5 clk = ~clk;

   seg7_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DUTY_BITS(DB)) dut (
      .clk(clk), .reset(reset), .digit_data(digit_data), .dp_in(dp_in),
      .blank(blank), .load(load), .brightness(brightness),
      .ENABLE(ENABLE), .LEDOUT(LEDOUT), .DP(DP), .frame_done(frame_done)
   );

   typedef struct {
      int         p;
      logic [3:0] en;
      logic [6:0] led;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state: position since reset, shown and latest-loaded frames.
   int          pos = 0;
   logic [15:0] cur_data, new_data;
   logic [3:0]  cur_dp, new_dp, cur_bl, new_bl;
   logic [2:0]  eff_b, br_req;
   logic [6:0]  seg_tab [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      pos = 0;
      cur_data = '0; new_data = '0;
      cur_dp = '0; new_dp = '0;
      cur_bl = '0; new_bl = '0;
      eff_b = '0;
   endtask

   // One clock of stimulus plus the expected pads after the following edge.
   task automatic cycle(input logic ld, input logic [15:0] d, input logic [3:0] dv, input logic [3:0] bv);
      exp_t e;
      int   digit, c, sp;
      logic [3:0] nib;
      logic lit;
      @(negedge clk);
      load = ld; digit_data = d; dp_in = dv; blank = bv;
      if (pos % 2 == 1) brightness = br_req;
      digit = (pos / RD) % ND;
      c     = pos % RD;
      sp    = c / SUBL;
      if (c % SUBL == 0) eff_b = brightness;
      lit = (sp <= int'(eff_b)) && !cur_bl[digit];
      e.p = pos; e.en = 4'hF; e.led = 7'h7F; e.dp = 1'b1;
      e.fd = (pos % FRAME == FRAME - 1);
      if (lit) begin
         e.en[digit] = 1'b0;
         nib   = 4'(cur_data >> (4 * digit));
         e.led = seg_tab[nib];
         e.dp  = ~cur_dp[digit];
      end
      exp_q.push_back(e);
      if (ld) begin new_data = d; new_dp = dv; new_bl = bv; end
      if (pos % FRAME == FRAME - 1) begin
         cur_data = new_data; cur_dp = new_dp; cur_bl = new_bl;
      end
      pos++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic run_to(input int phase);
      while (pos % FRAME != phase) idle(1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_enable"}, 32'(ENABLE), 32'hF);
      check({tag, "_ledout"}, 32'(LEDOUT), 32'h7F);
      check({tag, "_dp"}, 32'(DP), 32'h1);
      check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
   endtask

   // Asynchronous reset mid-cycle, held across edges, released mid-high phase.
   task automatic do_reset(input string tag);
      #2;
      load = 1'b0;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check_reset_state({tag, "_async"});
      repeat (2) @(posedge clk);
      #1;
      check_reset_state({tag, "_held"});
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   // Monitor: compare pads against the oldest expectation after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({ENABLE, LEDOUT, DP, frame_done} !== {e.en, e.led, e.dp, e.fd}) begin
               failures++;
               $display("FAIL scan p=%0d actual en=%b led=%h dp=%b fd=%b expected en=%b led=%h dp=%b fd=%b",
                        e.p, ENABLE, LEDOUT, DP, frame_done, e.en, e.led, e.dp, e.fd);
            end
         end
      end
   end

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      br_req = 3'd7;
      model_clear();

      // Power-on reset with no clock edge yet.
      #2 reset = 1'b0;
      #1 check_reset_state("por_async");
      repeat (2) @(posedge clk);
      #1 check_reset_state("por_held");
      #1 reset = 1'b1;

      // Load 1234 at cycle 5: frame 1 shows zeros, frame 2 shows 1234.
      for (int i = 0; i < 2 * int'(FRAME); i++) begin
         if (i == 5) cycle(1'b1, 16'h1234, 4'h0, 4'h0);
         else        idle(1);
      end

      // Brightness sweep: 3, 0, then full.
      br_req = 3'd3; idle(FRAME);
      br_req = 3'd0; idle(FRAME);
      br_req = 3'd7; idle(FRAME);

      // Blank digit 1 and light the decimal point on digit 3.
      idle(7);
      cycle(1'b1, 16'h5678, 4'b1000, 4'b0010);
      idle(2 * FRAME);

      // Load landing exactly on the frame-event cycle.
      run_to(FRAME - 1);
      cycle(1'b1, 16'hABCD, 4'h0, 4'h0);
      idle(FRAME);

      // Three loads in one frame: only the last shows.
      run_to(3);
      cycle(1'b1, 16'h1111, 4'h1, 4'h0);
      idle(20);
      cycle(1'b1, 16'h2222, 4'h2, 4'h4);
      idle(15);
      cycle(1'b1, 16'h9EF0, 4'h5, 4'h0);
      run_to(0);
      idle(FRAME);

      // Random loads and brightness changes.
      for (int i = 0; i < 6 * int'(FRAME); i++) begin
         if ($urandom_range(0, 15) == 0) br_req = 3'($urandom);
         if ($urandom_range(0, 7) == 0)
            cycle(1'b1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
         else
            idle(1);
      end

      // Reset in the middle of a slot, then scan resumes from digit 0.
      br_req = 3'd7;
      run_to(37);
      do_reset("mid");
      cycle(1'b1, 16'hC0DE, 4'h3, 4'h0);
      idle(2 * FRAME);

      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised, time-multiplexed seven-segment display driver for the board display path.
- Takes a packed nibble vector from the processor core and scans it across NUM_DIGITS common-anode digits.
- Adds over a fixed 4-digit scanner:
  - per-digit blanking and decimal points
  - PWM brightness control
  - frame-synchronous double-buffered data update
  - a frame_done strobe.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clk cycles per digit slot; must be a multiple of 2**DUTY_BITS.
- DUTY_BITS, 3, width of the brightness control; each slot splits into 2**DUTY_BITS sub-phases.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- digit_data  in  4*NUM_DIGITS  hex nibbles; digit i uses bits [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- blank  in  NUM_DIGITS  per-digit blank, active-high; the digit never lights.
- load  in  1  capture digit_data/dp_in/blank into the holding register this cycle.
- brightness  in  DUTY_BITS  on-time select; 0 = 1/2**DUTY_BITS, max = full on.
- ENABLE  out  NUM_DIGITS  digit anode enables, active-low.
- LEDOUT  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point segment, active-low.
- frame_done  out  1  one-cycle pulse after each complete scan frame.

Behaviour:
- **Reset.** While reset is low, asynchronously and with no clock edge:
  - ENABLE = all ones, LEDOUT = 7'h7F, DP = 1, frame_done = 0.
  - Slot counter, sub-phase, digit index, holding register and display register all clear to 0.
  - A reset asserted mid-frame takes effect immediately.
  - After release, the scan restarts at digit 0, slot cycle 0.
- **Counters.**
  - slot_cnt is $clog2(REFRESH_DIV) bits and counts 0..REFRESH_DIV-1, then wraps.
  - On a slot_cnt wrap, digit_idx increments. digit_idx wraps from NUM_DIGITS-1 to 0.
  - subphase = slot_cnt / (REFRESH_DIV >> DUTY_BITS), giving values 0..2**DUTY_BITS-1.
- **Frame boundary.** The frame event is slot_cnt==REFRESH_DIV-1 and digit_idx==NUM_DIGITS-1.
  - On that edge the display register takes the holding register contents.
  - If load is also high in that cycle, the display register takes the new digit_data directly.
  - frame_done is registered and is high for exactly the one cycle after the frame event.
- **Load.**
  - load captures into the holding register on any cycle.
  - The visible output changes only at a frame boundary, so a digit is never torn mid-scan.
  - Multiple loads within one frame: the last one wins.
- **Decode.** Hex 0-F maps to active-low segments:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- **Output generation.** Outputs are registered, with 1-cycle latency from counter state. For the current digit_idx d:
  - ENABLE[d] = 0 if and only if subphase <= brightness and the display-register blank[d] = 0.
  - All other ENABLE bits = 1.
  - LEDOUT = decode(nibble d).
  - DP = ~dp[d] while ENABLE[d] is low, else 1.
  - When no digit is enabled, LEDOUT = 7'h7F and DP = 1 (ghosting guard).
- **Brightness.** brightness is sampled every cycle; a change takes effect at the next sub-phase boundary.
- **Simultaneous events.** Reset dominates everything. A frame event and load in the same cycle resolve as stated above.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=16, DUTY_BITS=3 (sub-phase = 2 cycles, frame = 64 cycles).
1. **Reset.** Drive reset=0 mid-scan -> ENABLE=4'hF, LEDOUT=7'h7F, DP=1 immediately, frame_done=0. Release -> first slot drives ENABLE=4'b1110 with LEDOUT=7'h40.
2. **Frame-synchronous load.** After reset, pulse load with digit_data=16'h1234 at cycle 5, brightness=7:
   - Frame 1 shows 0 on all digits (LEDOUT=40).
   - frame_done pulses once, at cycle 64 after the first slot's output.
   - Frame 2 shows LEDOUT 19, 30, 24, 79 while ENABLE = 1110, 1101, 1011, 0111 respectively.
3. **Brightness.**
   - brightness=3 -> each ENABLE bit is low for 8 consecutive cycles, then high for 8, within its 16-cycle slot.
   - brightness=0 -> low 2 of 16.
   - brightness=7 -> low all 16.
4. **Blank.** Load blank=4'b0010 -> ENABLE[1] stays 1 for a whole frame. During digit 1's slot, LEDOUT=7F and DP=1. Other digits are unaffected.
5. **Decimal point.** Load dp_in=4'b1000, brightness=7 -> DP=0 only during the 16 cycles ENABLE[3]=0; DP=1 elsewhere.
6. **Load collision.** Assert load with 16'hABCD exactly on the frame-event cycle -> the following frame shows digits D, C, b, A (LEDOUT 21, 46, 03, 08). Three loads within one frame -> only the last value is displayed.
